// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer.
// Holds the instruction-memory address, advances it by +1 or by a signed
// branch offset, and runs the IDLE -> RUN -> HALTED control sequence with
// run-cycle and retired-instruction counters.
//
// Control handshake: Start is a one-cycle request that is acted on only in
// IDLE or HALTED; it moves the core into RUN on the next rising edge with the
// PC at START_ADDR. In RUN, Start is ignored, and HaltReq ends the program
// unless Stall is high in the same cycle. There is no ready/acknowledge
// signal: Running and Done report the state register directly.
module pc_fetch_ctrl #(
    parameter int             D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchTaken,
    input  logic [D-1:0]  Target,
    input  logic          HaltReq,
    output logic [D-1:0]  PC,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCnt,
    output logic [CW-1:0] InstrCnt,
    output logic [1:0]    StateDbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic [CW-1:0] instr_q, instr_d;

    logic [CW-1:0] cycle_inc;
    logic [CW-1:0] instr_inc;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    always_comb begin
        cycle_inc = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_ONE;
        instr_inc = (instr_q == CNT_MAX) ? instr_q : instr_q + CNT_ONE;
    end

    // Next-state, next-PC and counter update decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cycle_d = cycle_q;
        instr_d = instr_q;

        case (state_q)
            S_IDLE: begin
                pc_d = START_ADDR;
                if (Start) begin
                    state_d = S_RUN;
                    cycle_d = '0;
                    instr_d = '0;
                end
            end

            S_RUN: begin
                // Every RUN cycle counts, stalled or not.
                cycle_d = cycle_inc;
                if (!Stall) begin
                    instr_d = instr_inc;
                    if (HaltReq) begin
                        // PC stays on the halt instruction.
                        state_d = S_HALTED;
                    end else if (BranchTaken) begin
                        // D-bit add, carry dropped: two's-complement wrap
                        // makes Target behave as a signed offset.
                        pc_d = pc_q + Target;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end

            S_HALTED: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    cycle_d = '0;
                    instr_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                pc_d    = START_ADDR;
                cycle_d = '0;
                instr_d = '0;
            end
        endcase
    end

    // State, PC and counter registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    // Outputs are decodes of registered state only.
    always_comb begin
        PC       = pc_q;
        Running  = (state_q == S_RUN);
        Done     = (state_q == S_HALTED);
        CycleCnt = cycle_q;
        InstrCnt = instr_q;
        StateDbg = state_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl. A second instance with 3-bit
// counters shares all inputs so counter saturation is reachable quickly.
module tb_pc_fetch_ctrl;

    localparam int D  = 12;
    localparam int CW = 16;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Stall;
    logic          BranchTaken;
    logic [D-1:0]  Target;
    logic          HaltReq;
    logic [D-1:0]  PC;
    logic          Running;
    logic          Done;
    logic [CW-1:0] CycleCnt;
    logic [CW-1:0] InstrCnt;
    logic [1:0]    StateDbg;

    logic [D-1:0]  sat_pc;
    logic          sat_running;
    logic          sat_done;
    logic [2:0]    sat_cycle;
    logic [2:0]    sat_instr;
    logic [1:0]    sat_state;

    int checks;
    int errors;

    pc_fetch_ctrl #(.D(D), .START_ADDR('0), .CW(CW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .BranchTaken(BranchTaken),
        .Target     (Target),
        .HaltReq    (HaltReq),
        .PC         (PC),
        .Running    (Running),
        .Done       (Done),
        .CycleCnt   (CycleCnt),
        .InstrCnt   (InstrCnt),
        .StateDbg   (StateDbg)
    );

    pc_fetch_ctrl #(.D(D), .START_ADDR('0), .CW(3)) dut_sat (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .BranchTaken(BranchTaken),
        .Target     (Target),
        .HaltReq    (HaltReq),
        .PC         (sat_pc),
        .Running    (sat_running),
        .Done       (sat_done),
        .CycleCnt   (sat_cycle),
        .InstrCnt   (sat_instr),
        .StateDbg   (sat_state)
    );

    // Clock and reset block
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic sl, input logic br,
                         input logic [D-1:0] tg, input logic hr);
        Start       = st;
        Stall       = sl;
        BranchTaken = br;
        Target      = tg;
        HaltReq     = hr;
    endtask

    task automatic check_run(input string tag, input logic [D-1:0] pc,
                             input logic [CW-1:0] cyc, input logic [CW-1:0] ins);
        check({tag, "_pc"},  32'(PC), 32'(pc));
        check({tag, "_run"}, 32'(Running), 32'd1);
        check({tag, "_cyc"}, 32'(CycleCnt), 32'(cyc));
        check({tag, "_ins"}, 32'(InstrCnt), 32'(ins));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step();
        step();

        // Reset values
        check("rst_pc",   32'(PC), 32'h0);
        check("rst_run",  32'(Running), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_cyc",  32'(CycleCnt), 32'd0);
        check("rst_ins",  32'(InstrCnt), 32'd0);
        check("rst_state", 32'(StateDbg), 32'd0);

        // IDLE ignores branch/halt inputs
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 12'h005, 1'b1);
        step();
        check("idle_pc",  32'(PC), 32'h0);
        check("idle_run", 32'(Running), 32'd0);
        check("idle_done", 32'(Done), 32'd0);

        // Start pulse: first RUN cycle at PC 0
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_run("start", 12'h000, 0, 0);
        step();
        check_run("seq1", 12'h001, 1, 1);
        step();
        check_run("seq2", 12'h002, 2, 2);
        step();
        check_run("seq3", 12'h003, 3, 3);

        // Branches: +2 then -19
        drive(1'b0, 1'b0, 1'b1, 12'h002, 1'b0);
        step();
        check_run("br_pos", 12'h005, 4, 4);
        drive(1'b0, 1'b0, 1'b1, 12'hFED, 1'b0);
        step();
        check_run("br_neg", 12'hFF2, 5, 5);

        // Start in RUN is ignored; branch +13 to FFF
        drive(1'b1, 1'b0, 1'b1, 12'h00D, 1'b0);
        step();
        check_run("start_in_run", 12'hFFF, 6, 6);

        // Wrap at top with +1
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step();
        check_run("wrap_inc", 12'h000, 7, 7);

        // Jump to FF0 then +130 wraps to 072
        drive(1'b0, 1'b0, 1'b1, 12'hFF0, 1'b0);
        step();
        check_run("to_ff0", 12'hFF0, 8, 8);
        drive(1'b0, 1'b0, 1'b1, 12'd130, 1'b0);
        step();
        check_run("wrap_br", 12'h072, 9, 9);

        // 072 + F95 (-0x6B) = 007
        drive(1'b0, 1'b0, 1'b1, 12'hF95, 1'b0);
        step();
        check_run("to_7", 12'h007, 10, 10);
        check("sat_cyc_a", 32'(sat_cycle), 32'd7);
        check("sat_ins_a", 32'(sat_instr), 32'd7);

        // Stall 3 cycles with branch and halt asserted
        drive(1'b0, 1'b1, 1'b1, 12'h002, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_run($sformatf("stall%0d", i), 12'h007, CW'(11 + i), 10);
            check($sformatf("stall%0d_done", i), 32'(Done), 32'd0);
        end

        // Stall drops: branch taken
        drive(1'b0, 1'b0, 1'b1, 12'h002, 1'b0);
        step();
        check_run("post_stall", 12'h009, 14, 11);

        // Halt at PC 9
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step();
        check("halt_done", 32'(Done), 32'd1);
        check("halt_run",  32'(Running), 32'd0);
        check("halt_pc",   32'(PC), 32'h009);
        check("halt_cyc",  32'(CycleCnt), 32'd15);
        check("halt_ins",  32'(InstrCnt), 32'd12);

        // Frozen for 10 cycles with stray inputs
        drive(1'b0, 1'b0, 1'b1, 12'h123, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("frz_done", 32'(Done), 32'd1);
        check("frz_pc",   32'(PC), 32'h009);
        check("frz_cyc",  32'(CycleCnt), 32'd15);
        check("frz_ins",  32'(InstrCnt), 32'd12);
        check("sat_frz_cyc", 32'(sat_cycle), 32'd7);

        // Restart from HALTED
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_run("restart", 12'h000, 0, 0);
        check("restart_done", 32'(Done), 32'd0);
        check("sat_restart", 32'(sat_cycle), 32'd0);
        step();
        check_run("restart1", 12'h001, 1, 1);

        // Reach PC 20 then reset during a taken branch
        drive(1'b0, 1'b0, 1'b1, 12'd19, 1'b0);
        step();
        check_run("to_20", 12'd20, 2, 2);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 12'h005, 1'b0);
        step();
        check("mrst_pc",   32'(PC), 32'h0);
        check("mrst_run",  32'(Running), 32'd0);
        check("mrst_done", 32'(Done), 32'd0);
        check("mrst_cyc",  32'(CycleCnt), 32'd0);
        check("mrst_ins",  32'(InstrCnt), 32'd0);

        // Start from IDLE after reset
        Reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_run("idle_start", 12'h000, 0, 0);
        step();
        check_run("idle_start1", 12'h001, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
